fib_rr_scheduler: RTL



---
 rtl/fib_rr_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fib_rr_scheduler.sv
// -----------------------------------------------------------------------------
// fib_rr_scheduler
// Shares one Fibonacci producer between two burst consumers. One consumer is
// granted at a time. The producer enable is driven for exactly len_q cycles and
// the returned words are forwarded to the owner. A one-cycle DONE state closes
// each burst. When both consumers request, a round-robin pointer picks the one
// that was not served last.
// -----------------------------------------------------------------------------
module fib_rr_scheduler #(
   parameter int DW = 16,   // data word width, matches producer output
   parameter int CW = 4     // burst length counter width
) (
   input  logic          clock_1,
   input  logic          reset,
   input  logic          req0,
   input  logic [CW-1:0] len0,
   input  logic          req1,
   input  logic [CW-1:0] len1,
   output logic          f_en,
   input  logic          f_valid,
   input  logic [DW-1:0] f_out,
   output logic          grant0,
   output logic          grant1,
   output logic [DW-1:0] d_out,
   output logic          d_valid0,
   output logic          d_valid1,
   output logic          done0,
   output logic          done1,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] len_q;       // burst length frozen at grant
   logic [CW-1:0] issue_cnt;   // enabled cycles issued so far
   logic [CW-1:0] rcv_cnt;     // words forwarded so far
   logic          rr_ptr;      // consumer that wins a tie
   logic          owner;       // consumer holding the current grant

   logic          pick_valid;
   logic          pick_id;
   logic [CW-1:0] pick_len;
   logic [CW-1:0] issue_nxt;
   logic [CW-1:0] rcv_nxt;
   logic          word_ok;
   logic          last_word;

   // Arbitration choice and counter look-ahead used by the state machine.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
      pick_valid = req0 | req1;
      pick_id    = 1'b0;
      if (req0 && req1) begin
         pick_id = rr_ptr;
      end else if (req1) begin
         pick_id = 1'b1;
      end
      pick_len  = pick_id ? len1 : len0;
      issue_nxt = issue_cnt + CW'(1);
      rcv_nxt   = rcv_cnt + CW'(1);
      // A word is only accepted while the burst still owes words; this also
      // keeps rcv_cnt from ever passing len_q.
      word_ok   = (state == RUN) && f_valid && (rcv_cnt < len_q);
      last_word = word_ok && (rcv_nxt == len_q);
   end

   // Scheduler state machine with all outputs registered.
   always_ff @(posedge clock_1) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values, independent of statement order.
      if (reset) begin
         state     <= IDLE;
         len_q     <= '0;
         issue_cnt <= '0;
         rcv_cnt   <= '0;
         rr_ptr    <= 1'b0;
         owner     <= 1'b0;
         f_en      <= 1'b0;
         grant0    <= 1'b0;
         grant1    <= 1'b0;
         d_out     <= '0;
         d_valid0  <= 1'b0;
         d_valid1  <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         // Pulses are low unless a branch below raises them for this cycle.
         d_valid0 <= 1'b0;
         d_valid1 <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;

         case (state)
            IDLE: begin
               f_en <= 1'b0;
               if (pick_valid) begin
                  owner     <= pick_id;
                  grant0    <= ~pick_id;
                  grant1    <= pick_id;
                  len_q     <= pick_len;
                  issue_cnt <= '0;
                  rcv_cnt   <= '0;
                  busy      <= 1'b1;
                  if (pick_len != '0) begin
                     state <= RUN;
                     f_en  <= 1'b1;
                  end else begin
                     // An empty burst goes straight to completion without
                     // touching the producer.
                     state <= DONE;
                     done0 <= ~pick_id;
                     done1 <= pick_id;
                  end
               end
            end

            RUN: begin
               // Enable runs for len_q consecutive cycles from the first RUN
               // cycle; issue_cnt stops at len_q because f_en drops there.
               if (f_en) begin
                  issue_cnt <= issue_nxt;
                  f_en      <= (issue_nxt < len_q);
               end

               if (word_ok) begin
                  d_out    <= f_out;
                  d_valid0 <= ~owner;
                  d_valid1 <= owner;
                  rcv_cnt  <= rcv_nxt;
               end

               // The final word and the done pulse leave in the same cycle.
               if (last_word) begin
                  state <= DONE;
                  f_en  <= 1'b0;
                  done0 <= ~owner;
                  done1 <= owner;
               end
            end

            DONE: begin
               state  <= IDLE;
               f_en   <= 1'b0;
               grant0 <= 1'b0;
               grant1 <= 1'b0;
               busy   <= 1'b0;
               rr_ptr <= ~owner;
            end

            default: begin
               state  <= IDLE;
               f_en   <= 1'b0;
               grant0 <= 1'b0;
               grant1 <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
